// File: rtl/yolo_pkg.sv
// Constants shared by the YOLOv3-Tiny output packer and the downstream bitmap writer.
package yolo_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_CH    = 255;
    localparam int NUM_PIX   = 169;
    localparam int PIX_W     = NUM_CH * DATA_W;

    localparam int CH_CNT_W  = $clog2(NUM_CH);
    localparam int PIX_CNT_W = $clog2(NUM_PIX);

    localparam logic [CH_CNT_W-1:0]  CH_LAST  = CH_CNT_W'(NUM_CH - 1);
    localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(NUM_PIX - 1);
    localparam logic [CH_CNT_W-1:0]  CH_ONE   = CH_CNT_W'(1'b1);
    localparam logic [PIX_CNT_W-1:0] PIX_ONE  = PIX_CNT_W'(1'b1);

    // Channel counter successor, wrapping after the last channel of a pixel.
    function automatic logic [CH_CNT_W-1:0] ch_next(input logic [CH_CNT_W-1:0] cnt);
        return (cnt == CH_LAST) ? {CH_CNT_W{1'b0}} : cnt + CH_ONE;
    endfunction

    // Pixel counter successor, wrapping after the last pixel of a frame.
    function automatic logic [PIX_CNT_W-1:0] pix_next(input logic [PIX_CNT_W-1:0] cnt);
        return (cnt == PIX_LAST) ? {PIX_CNT_W{1'b0}} : cnt + PIX_ONE;
    endfunction

endpackage

// File: rtl/yolo_output_packer_if.sv
// Channel-in / packed-pixel-out bus between the detection layer, the packer and the file writer.
interface yolo_output_packer_if;
    import yolo_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              rd_en;
    logic [PIX_W-1:0]  data_out;
    logic              valid_out;
    logic              empty;
    logic              full;
    logic              frame_done;

    modport master (
        output data_in,
        output valid_in,
        output rd_en,
        input  ready_out,
        input  data_out,
        input  valid_out,
        input  empty,
        input  full,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  rd_en,
        output ready_out,
        output data_out,
        output valid_out,
        output empty,
        output full,
        output frame_done
    );

endinterface

// File: rtl/wide_fifo.sv
// Show-ahead FIFO for very wide words; head entry is always visible on rdata.
module wide_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             empty_r;
    logic             full_r;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;

    // Qualify requests: pop needs data, push needs room (a same-cycle pop frees a slot).
    always_comb begin
        pop_s       = pop & ~empty_r;
        push_s      = push & (~full_r | pop_s);
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
            full_r  <= (count_nxt_s == CNT_FULL);
            valid_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = empty_r;
    assign full  = full_r;
    assign valid = valid_r;
    assign count = count_r;

endmodule

// File: rtl/yolo_output_packer.sv
// Packs the 255 serial channel values of each detection pixel into one wide word,
// buffers the words for the file writer and marks the last pixel of every 13x13 frame.
module yolo_output_packer
    import yolo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    yolo_output_packer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam int ASM_W = (NUM_CH - 1) * DATA_W;

    logic [CH_CNT_W-1:0]  ch_cnt_r;
    logic [PIX_CNT_W-1:0] pix_cnt_r;
    logic                 frame_done_r;
    logic [ASM_W-1:0]     asm_r;

    logic                 last_ch_s;
    logic                 pop_req_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 push_s;
    logic [PIX_W-1:0]     push_word_s;

    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 fifo_valid_s;
    logic [CNT_W-1:0]     fifo_count_s;

    // Handshake: only the closing channel can stall, and only if no slot frees up this cycle.
    always_comb begin
        last_ch_s   = (ch_cnt_r == CH_LAST);
        pop_req_s   = bus.rd_en & ~fifo_empty_s;
        ready_s     = ~(last_ch_s & (fifo_count_s == CNT_FULL) & ~pop_req_s);
        accept_s    = bus.valid_in & ready_s;
        push_s      = accept_s & last_ch_s;
        push_word_s = {bus.data_in, asm_r};
    end

    // Channel and pixel counters plus the end-of-frame pulse.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ch_cnt_r     <= {CH_CNT_W{1'b0}};
            pix_cnt_r    <= {PIX_CNT_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            if (accept_s) begin
                ch_cnt_r <= ch_next(ch_cnt_r);
            end
            if (push_s) begin
                pix_cnt_r <= pix_next(pix_cnt_r);
            end
            frame_done_r <= push_s & (pix_cnt_r == PIX_LAST);
        end
    end

    // Assembly slots for channels 0..NUM_CH-2; the last channel bypasses straight into the FIFO.
    always_ff @(posedge Clk) begin
        for (int k = 0; k < NUM_CH - 1; k++) begin
            if (accept_s && (ch_cnt_r == CH_CNT_W'(k))) begin
                asm_r[k*DATA_W +: DATA_W] <= bus.data_in;
            end
        end
    end

    wide_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .push  (push_s),
        .wdata (push_word_s),
        .pop   (bus.rd_en),
        .rdata (bus.data_out),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .valid (fifo_valid_s),
        .count (fifo_count_s)
    );

    assign bus.ready_out  = ready_s;
    assign bus.empty      = fifo_empty_s;
    assign bus.full       = fifo_full_s;
    assign bus.valid_out  = fifo_valid_s;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_yolo_output_packer.sv
// Randomised scoreboard bench for yolo_output_packer with a cycle-level flag model.
module tb_yolo_output_packer;
    import yolo_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    yolo_output_packer_if bus();

    yolo_output_packer #(.DEPTH(DEPTH)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [PIX_W-1:0]  sb_q[$];
    logic [DATA_W-1:0] cur_px   [NUM_CH];
    logic [DATA_W-1:0] saved_px [NUM_CH];
    int rd_mode = 0;   // 0: always pop, 1: never pop, 2: random pop
    int n_pop = 0;
    int n_fd = 0;
    int n_issued = 0;

    // Reference state: FIFO occupancy, channel slot, pixel index, expected frame_done.
    int   m_occ = 0;
    int   m_ch = 0;
    int   m_pix = 0;
    logic m_fd = 1'b0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [PIX_W-1:0] pack_px();
        logic [PIX_W-1:0] w;
        for (int k = 0; k < NUM_CH; k++) w[k*DATA_W +: DATA_W] = cur_px[k];
        return w;
    endfunction

    task automatic rand_px();
        for (int k = 0; k < NUM_CH; k++) cur_px[k] = $urandom;
    endtask

    task automatic push_exp();
        sb_q.push_back(pack_px());
        n_issued++;
    endtask

    task automatic set_rd();
        case (rd_mode)
            0: bus.rd_en = 1'b1;
            1: bus.rd_en = 1'b0;
            default: bus.rd_en = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chans(input int lo, input int hi, input int gap_pct);
        for (int k = lo; k <= hi; k++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                bus.valid_in = 1'b0;
                set_rd();
                step();
            end
            bus.valid_in = 1'b1;
            bus.data_in  = cur_px[k];
            begin
                bit done = 1'b0;
                int t = 0;
                while (!done) begin
                    set_rd();
                    @(negedge clk);
                    done = bus.ready_out;
                    step();
                    t++;
                    if (!done && t >= 200) begin
                        check(1'b0, "accept_timeout", 64'(k), 64'(hi));
                        done = 1'b1;
                    end
                end
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic issue_pixel(input int gap_pct);
        push_exp();
        send_chans(0, NUM_CH - 1, gap_pct);
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        repeat (n) begin
            set_rd();
            step();
        end
    endtask

    // Reference model: checks registered flags and ready each cycle, then advances by the rules.
    initial forever begin
        bit exp_ready, acc, push, pop;
        @(negedge clk);
        if (!rst_n) begin
            m_occ = 0; m_ch = 0; m_pix = 0; m_fd = 1'b0;
            sb_q.delete();
        end else begin
            exp_ready = !(m_ch == NUM_CH - 1 && m_occ == DEPTH && !(bus.rd_en && m_occ > 0));
            check(bus.ready_out === exp_ready, "ready_out", 64'(bus.ready_out), 64'(exp_ready));
            check(bus.empty === (m_occ == 0), "empty", 64'(bus.empty), 64'(m_occ == 0));
            check(bus.full === (m_occ == DEPTH), "full", 64'(bus.full), 64'(m_occ == DEPTH));
            check(bus.valid_out === (m_occ != 0), "valid_out", 64'(bus.valid_out), 64'(m_occ != 0));
            check(bus.frame_done === m_fd, "frame_done", 64'(bus.frame_done), 64'(m_fd));
            acc  = bus.valid_in && exp_ready;
            push = acc && m_ch == NUM_CH - 1;
            pop  = bus.rd_en && m_occ > 0;
            m_occ = m_occ + int'(push) - int'(pop);
            m_fd  = push && m_pix == NUM_PIX - 1;
            if (push) m_pix = (m_pix == NUM_PIX - 1) ? 0 : m_pix + 1;
            if (acc)  m_ch  = (m_ch == NUM_CH - 1) ? 0 : m_ch + 1;
        end
    end

    // Scoreboard monitor: every word the writer would take is compared with the oldest expected word.
    initial forever begin
        logic [PIX_W-1:0] exp_w;
        int bad;
        @(negedge clk);
        if (rst_n && bus.valid_out === 1'b1 && bus.rd_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check(1'b0, "unexpected_word", 64'(n_pop), 64'(0));
            end else begin
                exp_w = sb_q.pop_front();
                bad = -1;
                for (int k = NUM_CH - 1; k >= 0; k--)
                    if (bus.data_out[k*DATA_W +: DATA_W] !== exp_w[k*DATA_W +: DATA_W]) bad = k;
                if (bad < 0)
                    check(1'b1, "word_data", 64'(0), 64'(0));
                else
                    check(1'b0, $sformatf("word_data pix%0d ch%0d", n_pop, bad),
                          64'(bus.data_out[bad*DATA_W +: DATA_W]), 64'(exp_w[bad*DATA_W +: DATA_W]));
            end
            n_pop++;
        end
        if (rst_n && bus.frame_done === 1'b1) n_fd++;
    end

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog: got %0d cycles expected fewer", 99000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.rd_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of a pixel.
        rd_mode = 0;
        repeat (3) begin rand_px(); issue_pixel(0); end
        rand_px();
        push_exp();
        send_chans(0, 100, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_pop = 0; n_fd = 0; n_issued = 0;
        @(negedge clk);
        check(bus.empty === 1'b1, "reset_empty", 64'(bus.empty), 64'(1));
        check(bus.frame_done === 1'b0, "reset_frame_done", 64'(bus.frame_done), 64'(0));
        check(bus.ready_out === 1'b1, "reset_ready", 64'(bus.ready_out), 64'(1));
        step();

        // Single known pixel.
        for (int k = 0; k < NUM_CH; k++) cur_px[k] = 32'h1000_0000 + 32'(k);
        issue_pixel(0);
        @(negedge clk);
        check(bus.valid_out === 1'b1, "single_valid", 64'(bus.valid_out), 64'(1));
        check(bus.data_out[31:0] === 32'h1000_0000, "single_ch0", 64'(bus.data_out[31:0]), 64'h1000_0000);
        check(bus.data_out[PIX_W-1 -: 32] === 32'h1000_00FE, "single_ch254",
              64'(bus.data_out[PIX_W-1 -: 32]), 64'h1000_00FE);
        step();
        @(negedge clk);
        check(bus.valid_out === 1'b0, "single_one_cycle", 64'(bus.valid_out), 64'(0));
        step();

        // Backpressure: fill the FIFO, stall the closing channel, release with one pop.
        rd_mode = 1;
        repeat (DEPTH) begin rand_px(); issue_pixel(0); end
        @(negedge clk);
        check(bus.full === 1'b1, "bp_full", 64'(bus.full), 64'(1));
        step();
        rand_px();
        push_exp();
        send_chans(0, NUM_CH - 2, 0);
        bus.valid_in = 1'b1;
        bus.data_in  = cur_px[NUM_CH-1];
        bus.rd_en    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check(bus.ready_out === 1'b0, "bp_stall", 64'(bus.ready_out), 64'(0));
            step();
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        check(bus.ready_out === 1'b1, "bp_release", 64'(bus.ready_out), 64'(1));
        step();
        bus.valid_in = 1'b0;
        bus.rd_en    = 1'b0;
        @(negedge clk);
        check(bus.full === 1'b1, "bp_count_kept", 64'(bus.full), 64'(1));
        step();
        rd_mode = 0;
        idle(8);

        // Push and pop together with DEPTH-1 words buffered.
        rd_mode = 1;
        repeat (DEPTH - 1) begin rand_px(); issue_pixel(0); end
        rand_px();
        push_exp();
        send_chans(0, NUM_CH - 2, 0);
        bus.valid_in = 1'b1;
        bus.data_in  = cur_px[NUM_CH-1];
        bus.rd_en    = 1'b1;
        @(negedge clk);
        check(bus.ready_out === 1'b1, "pp_ready", 64'(bus.ready_out), 64'(1));
        step();
        bus.valid_in = 1'b0;
        bus.rd_en    = 1'b0;
        @(negedge clk);
        check(bus.full === 1'b0, "pp_not_full", 64'(bus.full), 64'(0));
        step();
        rd_mode = 0;
        idle(8);

        // Same pixels gap-free and gapped; both must produce identical words.
        repeat (2) begin
            rand_px();
            saved_px = cur_px;
            rd_mode = 0;
            issue_pixel(0);
            cur_px = saved_px;
            rd_mode = 2;
            issue_pixel(50);
        end
        rd_mode = 0;
        idle(8);

        // Stream at full rate until two complete frames have been pushed.
        while (n_issued < 2 * NUM_PIX) begin
            rand_px();
            issue_pixel(0);
        end
        idle(6);

        check(n_fd == 2, "frame_done_pulses", 64'(n_fd), 64'(2));
        check(n_pop == 2 * NUM_PIX, "words_popped", 64'(n_pop), 64'(2 * NUM_PIX));
        check(sb_q.size() == 0, "scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
